// File: rtl/face_color_encoder_if.sv
// Handshake bundle for face_color_encoder.
//   Face side : face_codes, face_valid (to block), face_ready (from block)
//   RGB side  : red/green/blue, sticker_idx, rgb_valid, rgb_last (from block),
//               rgb_ready (to block)
// Modports:
//   master - the environment: it supplies faces and consumes RGB beats
//   slave  - the encoder itself
interface face_color_encoder_if #(
    parameter int NUM_STICKERS = 9
);
    logic [3*NUM_STICKERS-1:0] face_codes;
    logic                      face_valid;
    logic                      face_ready;
    logic [7:0]                red;
    logic [7:0]                green;
    logic [7:0]                blue;
    logic [3:0]                sticker_idx;
    logic                      rgb_valid;
    logic                      rgb_last;
    logic                      rgb_ready;

    modport master (
        output face_codes, face_valid, rgb_ready,
        input  face_ready, red, green, blue, sticker_idx, rgb_valid, rgb_last
    );

    modport slave (
        input  face_codes, face_valid, rgb_ready,
        output face_ready, red, green, blue, sticker_idx, rgb_valid, rgb_last
    );
endinterface

// File: rtl/face_color_encoder.sv
// face_color_encoder
//   Turns one cube face of 3-bit sticker colour codes back into a stream of
//   8-bit R/G/B beats, one sticker per beat, for the display/LED renderer.
//
// Ports:
//   clock    - single clock, all logic on the rising edge
//   reset_n  - synchronous, active-low reset
//   bus      - face_color_encoder_if.slave:
//                face_codes/face_valid/face_ready : face input handshake
//                red/green/blue/sticker_idx/rgb_valid/rgb_last/rgb_ready :
//                RGB beat output handshake
//   code_err - (only with FACE_CODE_ERR_EN) sticky flag, set when a beat
//              whose source code is 6 or 7 is accepted downstream
//
// Configuration macro: FACE_CODE_ERR_EN enables the code_err port/logic.
//
// Timing: a face accepted on edge N goes through a one-cycle LOAD state, so
// sticker 0 is presented after edge N+1. Beats then advance once per cycle
// while rgb_ready is high. After the last beat the block spends exactly one
// cycle in IDLE with face_ready=1 before it can take the next face.
// All outputs are registers; face_valid/rgb_ready only steer next state.
module face_color_encoder #(
    parameter int          NUM_STICKERS = 9,
    parameter logic [23:0] RGB_W        = 24'hFFFFFF,
    parameter logic [23:0] RGB_O        = 24'hFF8000,
    parameter logic [23:0] RGB_G        = 24'h00FF00,
    parameter logic [23:0] RGB_R        = 24'hFF0000,
    parameter logic [23:0] RGB_B        = 24'h0000FF,
    parameter logic [23:0] RGB_Y        = 24'hFFFF00
) (
    input  logic                  clock,
    input  logic                  reset_n,
    face_color_encoder_if.slave   bus
`ifdef FACE_CODE_ERR_EN
    ,
    output logic                  code_err
`endif
);

    // sticker_idx is a 4-bit port, so the code lookup table has 16 slots;
    // slots past the last sticker are tied to zero and never selected.
    localparam int         SLOTS    = 16;
    localparam logic [3:0] LAST_IDX = 4'(NUM_STICKERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t                    state_reg;
    logic [3*NUM_STICKERS-1:0] codes_reg;
    logic [3:0]                idx_reg;
    logic [23:0]               rgb_reg;
    logic                      face_ready_reg;
    logic                      rgb_valid_reg;
    logic                      rgb_last_reg;

    logic [2:0] code_slot [SLOTS];
    logic [3:0] next_idx;
    logic [2:0] cur_code;
    logic [2:0] next_code;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < NUM_STICKERS) begin : g_used
                assign code_slot[gi] = codes_reg[3*gi +: 3];
            end else begin : g_pad
                assign code_slot[gi] = 3'd0;
            end
        end
    endgenerate

    assign next_idx  = idx_reg + 4'd1;
    assign cur_code  = code_slot[idx_reg];
    assign next_code = code_slot[next_idx];

    // Codes 6 and 7 are not real colours and render as black.
    function automatic logic [23:0] code_to_rgb(input logic [2:0] code);
        case (code)
            3'd0:    code_to_rgb = RGB_W;
            3'd1:    code_to_rgb = RGB_O;
            3'd2:    code_to_rgb = RGB_G;
            3'd3:    code_to_rgb = RGB_R;
            3'd4:    code_to_rgb = RGB_B;
            3'd5:    code_to_rgb = RGB_Y;
            default: code_to_rgb = 24'h000000;
        endcase
    endfunction

`ifdef FACE_CODE_ERR_EN
    logic code_err_reg;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            codes_reg      <= '0;
            idx_reg        <= 4'd0;
            rgb_reg        <= 24'h000000;
            face_ready_reg <= 1'b1;
            rgb_valid_reg  <= 1'b0;
            rgb_last_reg   <= 1'b0;
`ifdef FACE_CODE_ERR_EN
            code_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // face_ready_reg is always 1 here, so face_valid alone
                    // completes the handshake.
                    if (bus.face_valid) begin
                        codes_reg      <= bus.face_codes;
                        idx_reg        <= 4'd0;
                        face_ready_reg <= 1'b0;
                        state_reg      <= LOAD;
                    end
                end

                LOAD: begin
                    rgb_reg       <= code_to_rgb(cur_code);
                    rgb_valid_reg <= 1'b1;
                    rgb_last_reg  <= (idx_reg == LAST_IDX);
                    state_reg     <= SEND;
                end

                SEND: begin
                    if (bus.rgb_ready) begin
`ifdef FACE_CODE_ERR_EN
                        if (cur_code[2:1] == 2'b11) begin
                            code_err_reg <= 1'b1;
                        end
`endif
                        if (idx_reg == LAST_IDX) begin
                            rgb_valid_reg  <= 1'b0;
                            rgb_last_reg   <= 1'b0;
                            face_ready_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            idx_reg      <= next_idx;
                            rgb_reg      <= code_to_rgb(next_code);
                            rgb_last_reg <= (next_idx == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_reg      <= IDLE;
                    face_ready_reg <= 1'b1;
                    rgb_valid_reg  <= 1'b0;
                    rgb_last_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.face_ready  = face_ready_reg;
    assign bus.red         = rgb_reg[23:16];
    assign bus.green       = rgb_reg[15:8];
    assign bus.blue        = rgb_reg[7:0];
    assign bus.sticker_idx = idx_reg;
    assign bus.rgb_valid   = rgb_valid_reg;
    assign bus.rgb_last    = rgb_last_reg;

`ifdef FACE_CODE_ERR_EN
    assign code_err = code_err_reg;
`endif

endmodule
